// File: rtl/cipher_bridge_pkg.sv
// rtl/cipher_bridge_pkg.sv - register map, bit indices and sequencer states for cipher_pio_bridge
package cipher_bridge_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h01;
  localparam logic [4:0] ADDR_KEY    = 5'h02;
  localparam logic [4:0] ADDR_DIN    = 5'h10;
  localparam logic [4:0] ADDR_DOUT   = 5'h18;

  localparam int CTRL_ENDE       = 0;
  localparam int CTRL_CORE_RESET = 1;
  localparam int CTRL_FLUSH      = 2;
  localparam int CTRL_IRQ_EN     = 3;

  localparam int STAT_IN_COUNT   = 0;
  localparam int STAT_OUT_COUNT  = 8;
  localparam int STAT_BUSY       = 16;
  localparam int STAT_STATE      = 17;
  localparam int STAT_IN_FULL    = 20;
  localparam int STAT_OUT_EMPTY  = 21;
  localparam int STAT_OVF        = 22;
  localparam int STAT_UNF        = 23;

  // Encoding is visible to software through STATUS[19:17].
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with head-of-queue read data, count and flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cipher_pio_bridge.sv
// rtl/cipher_pio_bridge.sv - register-mapped bridge from the Nios II bus to the block-cipher core
// Define BRIDGE_IRQ_EN to add the registered irq output and the CTRL.irq_en bit.
module cipher_pio_bridge
  import cipher_bridge_pkg::*;
#(
  parameter int KEY_WORDS     = 4,
  parameter int BLOCK_WORDS   = 4,
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 avs_address,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  output logic [32*KEY_WORDS-1:0]    core_key,
  output logic [32*BLOCK_WORDS-1:0]  core_block,
  output logic                       core_ende,
  output logic                       core_start,
  output logic                       core_reset,
  input  logic                       core_busy,
  input  logic [32*BLOCK_WORDS-1:0]  core_out
`ifdef BRIDGE_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam int BW = 32*BLOCK_WORDS;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  seq_state_t    state;
  logic [TW-1:0] wait_cnt;
  logic          ctrl_ende;
  logic          ctrl_core_reset;
  logic          irq_en;
  logic          ovf;
  logic          unf;
  logic [31:0]   key_q [KEY_WORDS];
  logic [31:0]   din_q [BLOCK_WORDS];

  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [CW-1:0] in_count, out_count;
  logic [BW-1:0] in_wdata, in_rdata, out_rdata;

  logic          wr_ctrl, wr_status, flush, din_last, dout_rd, dout_last, launch_ok;
  logic [31:0]   rd_mux;

  always_comb begin
    wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    wr_status = avs_write && (avs_address == ADDR_STATUS);
    flush     = wr_ctrl && avs_writedata[CTRL_FLUSH];
    din_last  = avs_write && (avs_address == ADDR_DIN + 5'(BLOCK_WORDS-1));
    dout_last = avs_read && (avs_address == ADDR_DOUT + 5'(BLOCK_WORDS-1));
    dout_rd   = 1'b0;
    for (int i = 0; i < BLOCK_WORDS; i++)
      if (avs_address == ADDR_DOUT + 5'(i)) dout_rd = avs_read;
  end

  // The last DIN word goes straight into the FIFO alongside the staged words.
  always_comb begin
    in_wdata = '0;
    for (int i = 0; i < BLOCK_WORDS-1; i++) in_wdata[32*i +: 32] = din_q[i];
    in_wdata[BW-1 -: 32] = avs_writedata;
  end

  assign launch_ok = !in_empty && !out_full && !ctrl_core_reset;
  assign in_push   = din_last && !in_full;
  assign in_pop    = (state == ST_IDLE) && launch_ok && !flush;
  assign out_push  = (state == ST_CAPTURE) && !ctrl_core_reset;
  assign out_pop   = dout_last && !out_empty;

  sync_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .flush(flush), .push(in_push), .pop(in_pop),
    .wdata(in_wdata), .rdata(in_rdata), .full(in_full), .empty(in_empty), .count(in_count)
  );

  sync_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset), .flush(flush), .push(out_push), .pop(out_pop),
    .wdata(core_out), .rdata(out_rdata), .full(out_full), .empty(out_empty), .count(out_count)
  );

  always_comb begin
    rd_mux = '0;
    if (avs_address == ADDR_CTRL) begin
      rd_mux[CTRL_ENDE]       = ctrl_ende;
      rd_mux[CTRL_CORE_RESET] = ctrl_core_reset;
      rd_mux[CTRL_IRQ_EN]     = irq_en;
    end
    if (avs_address == ADDR_STATUS) begin
      rd_mux[STAT_IN_COUNT +: 8]  = 8'(in_count);
      rd_mux[STAT_OUT_COUNT +: 8] = 8'(out_count);
      rd_mux[STAT_BUSY]           = core_busy;
      rd_mux[STAT_STATE +: 3]     = state;
      rd_mux[STAT_IN_FULL]        = in_full;
      rd_mux[STAT_OUT_EMPTY]      = out_empty;
      rd_mux[STAT_OVF]            = ovf;
      rd_mux[STAT_UNF]            = unf;
    end
    for (int i = 0; i < KEY_WORDS; i++)
      if (avs_address == ADDR_KEY + 5'(i)) rd_mux = key_q[i];
    for (int i = 0; i < BLOCK_WORDS; i++)
      if (avs_address == ADDR_DOUT + 5'(i)) rd_mux = out_empty ? 32'h0 : out_rdata[32*i +: 32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata    <= '0;
      ctrl_ende       <= 1'b0;
      ctrl_core_reset <= 1'b1;
      ovf             <= 1'b0;
      unf             <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++)   key_q[i] <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) din_q[i] <= '0;
    end else begin
      if (avs_read) avs_readdata <= rd_mux;
      if (wr_ctrl) begin
        ctrl_ende       <= avs_writedata[CTRL_ENDE];
        ctrl_core_reset <= avs_writedata[CTRL_CORE_RESET];
      end
      for (int i = 0; i < KEY_WORDS; i++)
        if (avs_write && (avs_address == ADDR_KEY + 5'(i))) key_q[i] <= avs_writedata;
      for (int i = 0; i < BLOCK_WORDS; i++)
        if (avs_write && (avs_address == ADDR_DIN + 5'(i))) din_q[i] <= avs_writedata;
      if (wr_status)                 ovf <= 1'b0;
      else if (din_last && in_full)  ovf <= 1'b1;
      if (wr_status)                 unf <= 1'b0;
      else if (dout_rd && out_empty) unf <= 1'b1;
    end
  end

  // Block and start pulse are registered together so the core sees both in LAUNCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      core_start <= 1'b0;
      core_block <= '0;
    end else begin
      core_start <= 1'b0;
      if (flush || ctrl_core_reset) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (launch_ok) begin
              state      <= ST_LAUNCH;
              core_block <= in_rdata;
              core_start <= 1'b1;
            end
          end
          ST_LAUNCH: begin
            state    <= ST_WAIT_BUSY;
            wait_cnt <= '0;
          end
          ST_WAIT_BUSY: begin
            if (core_busy)                                 state <= ST_WAIT_DONE;
            else if (wait_cnt == TW'(START_TIMEOUT - 1))   state <= ST_CAPTURE;
            else                                           wait_cnt <= wait_cnt + 1'b1;
          end
          ST_WAIT_DONE: if (!core_busy) state <= ST_CAPTURE;
          ST_CAPTURE:   state <= ST_IDLE;
          default:      state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    core_key = '0;
    for (int i = 0; i < KEY_WORDS; i++) core_key[32*i +: 32] = key_q[i];
  end

  assign core_ende  = ctrl_ende;
  assign core_reset = ctrl_core_reset;

`ifdef BRIDGE_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= avs_writedata[CTRL_IRQ_EN];
      irq <= irq_en && ((out_count != '0) || ovf || unf);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule
